// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a registered valid/ready stage with a one-entry skid buffer.
// Define IMM_GEN_CSR_ZIMM_EN to decode CSR zero-extended immediates (fmt 7).
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic [TAG_W-1:0] tag_o
);

    typedef enum logic [2:0] {
        FmtNone  = 3'd0,
        FmtI     = 3'd1,
        FmtS     = 3'd2,
        FmtB     = 3'd3,
        FmtU     = 3'd4,
        FmtJ     = 3'd5,
        FmtShamt = 3'd6,
        FmtCsrz  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     m_q, m_d, s_q, s_d, dec;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       pop, push;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    always_comb begin
        dec.valid = 1'b1;
        dec.tag   = tag_i;
        dec.fmt   = FmtNone;
        dec.imm   = '0;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec.fmt = FmtI;
                dec.imm = XLEN'($signed(instr_i[31:20]));
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // funct7/funct6 sit above the shift amount and must not leak in
                    dec.fmt      = FmtShamt;
                    dec.imm[4:0] = instr_i[24:20];
                    if (XLEN == 64) dec.imm[5] = instr_i[25];
                end else begin
                    dec.fmt = FmtI;
                    dec.imm = XLEN'($signed(instr_i[31:20]));
                end
            end
            7'b0100011: begin
                dec.fmt = FmtS;
                dec.imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            7'b1100011: begin
                dec.fmt = FmtB;
                dec.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                         instr_i[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FmtU;
                dec.imm = XLEN'($signed({instr_i[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec.fmt = FmtJ;
                dec.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                         instr_i[30:21], 1'b0}));
            end
            7'b1110011: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                case (funct3)
                    3'b101, 3'b110, 3'b111: begin
                        dec.fmt = FmtCsrz;
                        dec.imm = XLEN'(instr_i[19:15]);
                    end
                    3'b001, 3'b010, 3'b011: begin
                        dec.fmt = FmtI;
                        dec.imm = XLEN'($signed(instr_i[31:20]));
                    end
                    default: begin
                        dec.fmt = FmtNone;
                        dec.imm = '0;
                    end
                endcase
`else
                dec.fmt = FmtI;
                dec.imm = XLEN'($signed(instr_i[31:20]));
`endif
            end
            default: begin
                dec.fmt = FmtNone;
                dec.imm = '0;
            end
        endcase
    end

    assign in_ready_o = ~s_q.valid;
    assign pop        = m_q.valid & out_ready_i;
    assign push       = in_valid_i & ~s_q.valid;

    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (flush_i) begin
            // data fields hold; only the valid bits drop
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (!m_q.valid || pop) begin
            if (s_q.valid) begin
                m_d       = s_q;
                s_d.valid = 1'b0;
            end else if (push) begin
                m_d = dec;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (push) begin
            s_d = dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign out_valid_o = m_q.valid;
    assign imm_o       = m_q.imm;
    assign fmt_o       = m_q.fmt;
    assign tag_o       = m_q.tag;

endmodule
